msgbus_switch: RTL and testbench

- Network-side counterpart of the per-core message unit's bus ports: it consumes the core-side send handshake (val/ack) and drives the core-side receive handshake (val/rdy).
- Connects NUM_HARTS message units through a single-stage crossbar. Each destination output is arbitrated round-robin among the sources addressing it.
- Stamps each delivered message with the sender's address. Drops and counts messages sent to addresses outside the switch.

---
 rtl/msgbus_switch.sv | 144 ++++++++++++++
 tb/tb_msgbus_switch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msgbus_switch.sv
// Single-stage crossbar between NUM_HARTS message units with per-destination
// round-robin arbitration, sender stamping and a saturating bad-address counter.
module msgbus_switch #(
  parameter int          NUM_HARTS    = 4,
  parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_HARTS-1:0]    snd_val_i,
  output logic [NUM_HARTS-1:0]    snd_ack_o,
  input  logic [NUM_HARTS*32-1:0] snd_dst_i,
  input  logic [NUM_HARTS*32-1:0] snd_tag_i,
  input  logic [NUM_HARTS*64-1:0] snd_msg_i,
  output logic [NUM_HARTS-1:0]    rcv_val_o,
  input  logic [NUM_HARTS-1:0]    rcv_rdy_i,
  output logic [NUM_HARTS*32-1:0] rcv_src_o,
  output logic [NUM_HARTS*32-1:0] rcv_tag_o,
  output logic [NUM_HARTS*64-1:0] rcv_msg_o,
  output logic [15:0]             err_count_o
);

  localparam int IW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  logic [NUM_HARTS-1:0]           ack_reg;
  logic [NUM_HARTS-1:0]           ack_next;
  logic [NUM_HARTS-1:0]           req;
  logic [NUM_HARTS-1:0]           dst_ok;
  logic [NUM_HARTS-1:0]           bad;
  logic [NUM_HARTS*32-1:0]        idx_flat;
  // grant_flat[d*NUM_HARTS + s] is set when destination d grants source s
  logic [NUM_HARTS*NUM_HARTS-1:0] grant_flat;
  logic [15:0]                    err_count_reg;
  logic [15:0]                    err_count_next;
  logic [16:0]                    err_sum;

  genvar gi;

  // A source that is being acked this cycle is already consumed, so it is masked.
  generate
    for (gi = 0; gi < NUM_HARTS; gi++) begin : g_src
      assign idx_flat[32*gi +: 32] = snd_dst_i[32*gi +: 32] - BASE_ADDRESS;
      assign dst_ok[gi]            = idx_flat[32*gi +: 32] < 32'(NUM_HARTS);
      assign req[gi]               = snd_val_i[gi] & ~ack_reg[gi];
      assign bad[gi]               = req[gi] & ~dst_ok[gi];
    end
  endgenerate

  always_comb begin
    ack_next = bad;
    for (int d = 0; d < NUM_HARTS; d++) begin
      for (int s = 0; s < NUM_HARTS; s++) begin
        if (grant_flat[d*NUM_HARTS + s]) ack_next[s] = 1'b1;
      end
    end
  end

  always_comb begin
    err_sum = {1'b0, err_count_reg};
    for (int s = 0; s < NUM_HARTS; s++) begin
      err_sum = err_sum + 17'(bad[s]);
    end
    err_count_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_reg       <= '0;
      err_count_reg <= '0;
    end else begin
      ack_reg       <= ack_next;
      err_count_reg <= err_count_next;
    end
  end

  assign snd_ack_o   = ack_reg;
  assign err_count_o = err_count_reg;

  generate
    for (gi = 0; gi < NUM_HARTS; gi++) begin : g_dst
      logic                 val_reg;
      logic [31:0]          src_reg;
      logic [31:0]          tag_reg;
      logic [63:0]          msg_reg;
      logic [IW-1:0]        last_reg;
      logic [IW-1:0]        sel;
      logic [NUM_HARTS-1:0] cand;
      logic [NUM_HARTS-1:0] grant_oh;
      logic                 grant_any;
      logic                 slot_free;
      int                   cs;

      assign slot_free = ~val_reg | rcv_rdy_i[gi];

      // Round-robin search starting just after the last granted source.
      always_comb begin
        cand      = '0;
        grant_oh  = '0;
        grant_any = 1'b0;
        sel       = '0;
        cs        = 0;
        for (int s = 0; s < NUM_HARTS; s++) begin
          cand[s] = req[s] & dst_ok[s] & (idx_flat[32*s +: 32] == 32'(gi));
        end
        if (slot_free) begin
          for (int k = 1; k <= NUM_HARTS; k++) begin
            cs = int'(last_reg) + k;
            if (cs >= NUM_HARTS) cs = cs - NUM_HARTS;
            if (!grant_any && cand[cs]) begin
              grant_any    = 1'b1;
              sel          = IW'(cs);
              grant_oh[cs] = 1'b1;
            end
          end
        end
      end

      assign grant_flat[gi*NUM_HARTS +: NUM_HARTS] = grant_oh;

      always_ff @(posedge clk) begin
        if (rst) begin
          val_reg  <= 1'b0;
          src_reg  <= '0;
          tag_reg  <= '0;
          msg_reg  <= '0;
          last_reg <= IW'(NUM_HARTS - 1);
        end else if (grant_any) begin
          val_reg  <= 1'b1;
          src_reg  <= BASE_ADDRESS + 32'(sel);
          tag_reg  <= snd_tag_i[32*int'(sel) +: 32];
          msg_reg  <= snd_msg_i[64*int'(sel) +: 64];
          last_reg <= sel;
        end else if (rcv_rdy_i[gi]) begin
          val_reg  <= 1'b0;
        end
      end

      assign rcv_val_o[gi]         = val_reg;
      assign rcv_src_o[32*gi +: 32] = src_reg;
      assign rcv_tag_o[32*gi +: 32] = tag_reg;
      assign rcv_msg_o[64*gi +: 64] = msg_reg;
    end
  endgenerate

endmodule

// File: tb/tb_msgbus_switch.sv
// Bench for msgbus_switch: reset/one-shot vector table, hand-written multi-cycle
// sequences, and a randomized run checked against a message scoreboard.
module tb_msgbus_switch;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   snd_val, snd_ack, rcv_val, rcv_rdy;
  logic [N*32-1:0] snd_dst, snd_tag, rcv_src, rcv_tag;
  logic [N*64-1:0] snd_msg, rcv_msg;
  logic [15:0]    err_count;

  msgbus_switch #(.NUM_HARTS(N), .BASE_ADDRESS(BASE)) dut (
    .clk(clk), .rst(rst),
    .snd_val_i(snd_val), .snd_ack_o(snd_ack), .snd_dst_i(snd_dst),
    .snd_tag_i(snd_tag), .snd_msg_i(snd_msg),
    .rcv_val_o(rcv_val), .rcv_rdy_i(rcv_rdy), .rcv_src_o(rcv_src),
    .rcv_tag_o(rcv_tag), .rcv_msg_o(rcv_msg), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    snd_val = '0; snd_dst = '0; snd_tag = '0; snd_msg = '0; rcv_rdy = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_src(input int s, input logic [31:0] dst, input logic [31:0] tag,
                         input logic [63:0] msg);
    snd_val[s] = 1'b1;
    snd_dst[32*s +: 32] = dst;
    snd_tag[32*s +: 32] = tag;
    snd_msg[64*s +: 64] = msg;
  endtask

  task automatic chk_slot(input string name, input int d, input int s,
                          input logic [31:0] tag, input logic [63:0] msg);
    chk({name, "_val"}, 64'(rcv_val[d]), 64'd1);
    chk({name, "_src"}, 64'(rcv_src[32*d +: 32]), 64'(BASE + 32'(s)));
    chk({name, "_tag"}, 64'(rcv_tag[32*d +: 32]), 64'(tag));
    chk({name, "_msg"}, rcv_msg[64*d +: 64], msg);
  endtask

  // One-shot vectors applied from a fresh reset: src s carries tag 0x11+s, msg 0xDEAD+s.
  typedef struct {
    logic [3:0]       val;
    logic [3:0][31:0] dst;
    logic [3:0]       exp_ack;
    logic [3:0]       exp_rcv;
    logic [3:0][3:0]  exp_src;
    logic [15:0]      exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d0, d1, d2, d3,
                              input logic [3:0] ea, input logic [3:0] er,
                              input logic [3:0] s0, s1, s2, s3, input logic [15:0] ee);
    vec_t r;
    r.val = v; r.dst = {d3, d2, d1, d0}; r.exp_ack = ea; r.exp_rcv = er;
    r.exp_src = {s3, s2, s1, s0}; r.exp_err = ee;
    return r;
  endfunction

  // Scoreboard of accepted messages; cross-source order is free, so pops search by (src,dst).
  typedef struct {
    int          src;
    int          dst;
    logic [31:0] tag;
    logic [63:0] msg;
  } item_t;

  item_t       exp_q[$];
  int          err_model;
  logic [N-1:0] cons;
  int          seq;

  task automatic rand_cycle(input bit gen);
    logic [31:0] idx;
    int          s_dec;
    int          hit;
    step();
    for (int s = 0; s < N; s++) begin
      if (snd_ack[s]) begin
        idx = snd_dst[32*s +: 32] - BASE;
        if (idx < 32'(N)) exp_q.push_back('{s, int'(idx), snd_tag[32*s +: 32], snd_msg[64*s +: 64]});
        else err_model++;
      end
    end
    chk("rand_err", 64'(err_count), 64'(err_model > 65535 ? 65535 : err_model));
    for (int s = 0; s < N; s++) begin
      if (cons[s]) begin
        snd_val[s] = 1'b0;
        cons[s] = 1'b0;
      end
      if (!snd_val[s] && !snd_ack[s] && gen && $urandom_range(0, 2) == 0) begin
        int r;
        logic [31:0] dst;
        r = $urandom_range(0, 9);
        if (r < 8)       dst = BASE + $urandom_range(0, N - 1);
        else if (r == 8) dst = BASE + 32'(N) + $urandom_range(0, 100);
        else             dst = BASE - 32'd1 - $urandom_range(0, 5);
        seq++;
        set_src(s, dst, {8'(s), 24'(seq)}, {$urandom, $urandom});
      end
      if (snd_ack[s]) cons[s] = 1'b1;
    end
    for (int d = 0; d < N; d++) rcv_rdy[d] = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int d = 0; d < N; d++) begin
      if (rcv_val[d] && rcv_rdy[d]) begin
        s_dec = int'(rcv_src[32*d +: 32] - BASE);
        hit = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (hit < 0 && exp_q[i].src == s_dec && exp_q[i].dst == d) hit = i;
        end
        chk("rand_pop_match", 64'(hit >= 0), 64'd1);
        if (hit >= 0) begin
          chk("rand_pop_tag", 64'(rcv_tag[32*d +: 32]), 64'(exp_q[hit].tag));
          chk("rand_pop_msg", rcv_msg[64*d +: 64], exp_q[hit].msg);
          exp_q.delete(hit);
        end
      end
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   order[6];
    int   dcnt[N];
    int   acks;
    int   c;

    vecs[0] = mk(4'b0001, BASE+2, 0, 0, 0, 4'b0001, 4'b0100, 0, 0, 0, 0, 16'd0);
    vecs[1] = mk(4'b1011, BASE+2, BASE+2, 0, BASE+2, 4'b0001, 4'b0100, 0, 0, 0, 0, 16'd0);
    vecs[2] = mk(4'b0111, BASE+1, BASE+0, BASE+2, 0, 4'b0111, 4'b0111, 1, 0, 2, 0, 16'd0);
    vecs[3] = mk(4'b0001, BASE+7, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 16'd1);
    vecs[4] = mk(4'b1111, BASE+3, BASE+3, BASE-1, BASE+3, 4'b0101, 4'b1000, 0, 0, 0, 0, 16'd1);
    vecs[5] = mk(4'b1000, 0, 0, 0, BASE+3, 4'b1000, 4'b1000, 0, 0, 0, 3, 16'd0);
    vecs[6] = mk(4'b1100, 0, 0, BASE+4, BASE+0, 4'b1100, 4'b0001, 3, 0, 0, 0, 16'd1);
    vecs[7] = mk(4'b1111, BASE+3, BASE+2, BASE+1, BASE+0, 4'b1111, 4'b1111, 3, 2, 1, 0, 16'd0);

    clear_inputs();
    do_reset();
    chk("reset_ack", 64'(snd_ack), 64'd0);
    chk("reset_rcv_val", 64'(rcv_val), 64'd0);
    chk("reset_err", 64'(err_count), 64'd0);
    chk("reset_src", rcv_src[63:0], 64'd0);
    chk("reset_tag", rcv_tag[63:0], 64'd0);
    chk("reset_msg", rcv_msg[63:0], 64'd0);

    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      do_reset();
      for (int s = 0; s < N; s++) begin
        if (vecs[i].val[s]) set_src(s, vecs[i].dst[s], 32'h11 + 32'(s), 64'hDEAD + 64'(s));
      end
      step();
      chk("vec_ack", 64'(snd_ack), 64'(vecs[i].exp_ack));
      chk("vec_rcv_val", 64'(rcv_val), 64'(vecs[i].exp_rcv));
      chk("vec_err", 64'(err_count), 64'(vecs[i].exp_err));
      for (int d = 0; d < N; d++) begin
        if (vecs[i].exp_rcv[d]) begin
          chk_slot("vec_slot", d, int'(vecs[i].exp_src[d]),
                   32'h11 + 32'(vecs[i].exp_src[d]), 64'hDEAD + 64'(vecs[i].exp_src[d]));
        end
      end
      snd_val = '0;
      step();
      chk("vec_ack_pulse", 64'(snd_ack), 64'd0);
      chk("vec_rcv_drop", 64'(rcv_val), 64'd0);
      $display("vector %0d ack=%b rcv_val=%b err=%0d", i, vecs[i].exp_ack, vecs[i].exp_rcv,
               err_count);
    end

    // Contention: sources 0,1,3 continuously target dst 2.
    clear_inputs();
    do_reset();
    order = '{0, 1, 3, 0, 1, 3};
    cons = '0;
    for (int s = 0; s < N; s++) dcnt[s] = 0;
    set_src(0, BASE+2, 32'h000, 64'h0);
    set_src(1, BASE+2, 32'h100, 64'h1);
    set_src(3, BASE+2, 32'h300, 64'h3);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_ack", 64'(snd_ack), 64'(1 << order[k]));
      chk_slot("rr_slot", 2, order[k], 32'(order[k] * 256 + dcnt[order[k]]), 64'(order[k]));
      $display("contention grant %0d -> src %0d", k, rcv_src[64 +: 32] - BASE);
      dcnt[order[k]]++;
      for (int s = 0; s < N; s++) begin
        if (cons[s]) snd_tag[32*s +: 32] = 32'(s * 256 + dcnt[s]);
        cons[s] = snd_ack[s];
      end
    end

    // Backpressure on dst 1 with a waiting source, then pop+load in one cycle.
    clear_inputs();
    do_reset();
    set_src(0, BASE+1, 32'hA, 64'hA0);
    step();
    chk("bp_first_ack", 64'(snd_ack), 64'b0001);
    snd_val = '0;
    set_src(2, BASE+1, 32'hB, 64'hB0);
    rcv_rdy[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_slot("bp_hold", 1, 0, 32'hA, 64'hA0);
      chk("bp_no_ack", 64'(snd_ack), 64'd0);
    end
    rcv_rdy[1] = 1'b1;
    step();
    chk_slot("bp_reload", 1, 2, 32'hB, 64'hB0);
    chk("bp_reload_ack", 64'(snd_ack), 64'b0100);
    snd_val = '0;
    step();
    chk("bp_drain", 64'(rcv_val), 64'd0);
    $display("backpressure sequence done");

    // Counter saturation: every source sends to bad addresses continuously.
    clear_inputs();
    do_reset();
    for (int s = 0; s < N; s++) set_src(s, BASE + 32'd7 + 32'(s), 32'(s), 64'(s));
    acks = 0;
    c = 0;
    while (c < 40000 && acks < 65540) begin
      step();
      acks += $countones(snd_ack);
      if (c % 256 == 0) chk("sat_track", 64'(err_count), 64'(acks > 65535 ? 65535 : acks));
      chk("sat_no_rcv", 64'(rcv_val), 64'd0);
      c++;
    end
    chk("sat_budget", 64'(acks >= 65540), 64'd1);
    chk("sat_err", 64'(err_count), 64'hFFFF);
    $display("saturation acks=%0d err=%0h", acks, err_count);

    // Reset while slots are full and src3 is waiting.
    clear_inputs();
    do_reset();
    rcv_rdy = '0;
    set_src(0, BASE+1, 32'hC0, 64'hC0);
    set_src(1, BASE+0, 32'hC1, 64'hC1);
    set_src(2, BASE+2, 32'hC2, 64'hC2);
    set_src(3, BASE+2, 32'hC3, 64'hC3);
    step();
    chk("rst_pre_ack", 64'(snd_ack), 64'b0111);
    snd_val[2:0] = '0;
    step();
    chk("rst_pre_wait", 64'(snd_ack), 64'd0);
    chk("rst_pre_full", 64'(rcv_val), 64'b0111);
    do_reset();
    chk("rst_mid_val", 64'(rcv_val), 64'd0);
    chk("rst_mid_ack", 64'(snd_ack), 64'd0);
    rcv_rdy = '1;
    set_src(2, BASE+2, 32'hD2, 64'hD2);
    step();
    chk("rst_ptr_ack", 64'(snd_ack), 64'b0100);
    chk_slot("rst_ptr_slot", 2, 2, 32'hD2, 64'hD2);
    snd_val[2] = 1'b0;
    step();
    chk("rst_held_ack", 64'(snd_ack), 64'b1000);
    chk_slot("rst_held_slot", 2, 3, 32'hC3, 64'hC3);
    snd_val[3] = 1'b0;
    step();
    chk("rst_once_ack", 64'(snd_ack), 64'd0);
    chk("rst_once_val", 64'(rcv_val), 64'd0);
    $display("reset mid-operation sequence done");

    // Randomized traffic against the scoreboard, then drain.
    clear_inputs();
    do_reset();
    exp_q.delete();
    err_model = 0;
    cons = '0;
    seq = 0;
    for (int k = 0; k < 3000; k++) rand_cycle(1'b1);
    c = 0;
    while (c < 200 && (exp_q.size() != 0 || snd_val != '0 || cons != '0 || rcv_val != '0)) begin
      rand_cycle(1'b0);
      c++;
    end
    chk("rand_drain_queue", 64'(exp_q.size()), 64'd0);
    chk("rand_drain_val", 64'(snd_val), 64'd0);
    chk("rand_drain_rcv", 64'(rcv_val), 64'd0);
    $display("random run messages=%0d bad=%0d", seq, err_model);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
